// File: rtl/audio_pkg.sv
// Shared constants and types for the I2S audio demo: divider bit map, frame
// geometry and the sample type.
package audio_pkg;

  localparam int DIV_W       = 11;
  localparam int MCLK_BIT    = 2;
  localparam int BCLK_BIT    = 4;
  localparam int SLOT_LSB    = 5;
  localparam int SLOT_MSB    = 10;

  localparam int SLOT_BITS   = 32;   // system clocks per I2S slot
  localparam int SAMPLE_W    = 16;
  localparam int FRAME_SLOTS = 64;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Left word then right word, each a 16-bit sample padded to 32 slots.
  function automatic logic [FRAME_SLOTS-1:0] frame_word(input sample_t s);
    return {s, 16'h0000, s, 16'h0000};
  endfunction

endpackage

// File: rtl/audio_i2s_tx.sv
// Philips I2S transmitter: free-running divider, MCLK/BCLK/WS generation and a
// 64-bit frame shift register with the standard one-bit data delay.
module i2s_tx
  import audio_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  sample_t sample,
  output logic    load,
  output logic    mclk,
  output logic    bclk,
  output logic    sync,
  output logic    tx
);

  logic [DIV_W-1:0]       div;
  logic [FRAME_SLOTS-1:0] shreg;
  logic                   slot_end;

  // Last clock of a slot: the next edge is a BCLK falling edge.
  assign slot_end = (div[SLOT_LSB-1:0] == SLOT_LSB'(SLOT_BITS - 1));
  // Loading on the slot-0 -> slot-1 boundary gives the one-bit I2S delay.
  assign load     = (div == DIV_W'(SLOT_BITS - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, which keeps all outputs one clk behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div   <= '0;
      shreg <= '0;
      mclk  <= 1'b0;
      bclk  <= 1'b0;
      sync  <= 1'b0;
      tx    <= 1'b0;
    end else begin
      div <= div + 1'b1;
      if (load)
        shreg <= frame_word(sample);
      else if (slot_end)
        shreg <= {shreg[FRAME_SLOTS-2:0], 1'b0};
      mclk <= div[MCLK_BIT];
      bclk <= div[BCLK_BIT];
      sync <= div[SLOT_MSB];
      tx   <= shreg[FRAME_SLOTS-1];
    end
  end

endmodule

// File: rtl/audio_i2s_top.sv
// Audio demo top: square-wave tone generator feeding the I2S transmitter,
// plus heartbeat, polarity and running LEDs.
module audio_i2s_top
  import audio_pkg::*;
#(
  parameter sample_t AMPLITUDE    = 16'sh2000,
  parameter int      TONE_HALF    = 24,
  parameter int      LED_DIV_BITS = 26
) (
  input  logic clk1000,
  input  logic cpu_reset0,
  output logic user_led0,
  output logic user_led1,
  output logic user_led2,
  output logic i2s_tx_mclk0,
  output logic i2s_tx0_clk,
  output logic i2s_tx0_sync,
  output logic i2s_tx0_tx
);

  localparam int TONE_W = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

  logic                    load;
  logic                    tone_neg;
  logic [TONE_W-1:0]       tone_cnt;
  logic [LED_DIV_BITS-2:0] led_cnt;
  logic                    led_msb;
  sample_t                 sample;

  assign sample = tone_neg ? sample_t'(-AMPLITUDE) : AMPLITUDE;

  i2s_tx u_i2s_tx (
    .clk    (clk1000),
    .rst_n  (cpu_reset0),
    .sample (sample),
    .load   (load),
    .mclk   (i2s_tx_mclk0),
    .bclk   (i2s_tx0_clk),
    .sync   (i2s_tx0_sync),
    .tx     (i2s_tx0_tx)
  );

  // The heartbeat MSB is kept as a toggle flop over the lower counter bits,
  // which behaves exactly like the top bit of a LED_DIV_BITS-wide counter.
  always_ff @(posedge clk1000 or negedge cpu_reset0) begin
    if (!cpu_reset0) begin
      tone_neg  <= 1'b0;
      tone_cnt  <= '0;
      led_cnt   <= '0;
      led_msb   <= 1'b0;
      user_led0 <= 1'b0;
      user_led1 <= 1'b0;
      user_led2 <= 1'b0;
    end else begin
      if (load) begin
        if (tone_cnt == TONE_W'(TONE_HALF - 1)) begin
          tone_cnt <= '0;
          tone_neg <= ~tone_neg;
        end else begin
          tone_cnt <= tone_cnt + 1'b1;
        end
      end
      led_cnt <= led_cnt + 1'b1;
      if (&led_cnt)
        led_msb <= ~led_msb;
      user_led0 <= led_msb;
      user_led1 <= ~tone_neg;
      user_led2 <= 1'b1;
    end
  end

endmodule

// File: tb/tb_audio_i2s_top.sv
// Scoreboard bench for audio_i2s_top: expected I2S bits are queued per frame
// and a monitor compares them on every BCLK rising edge.
module tb_audio_i2s_top;

  localparam int TH = 4;   // shortened tone half-period keeps the run short

  logic clk1000    = 1'b0;
  logic cpu_reset0 = 1'b0;
  logic user_led0, user_led1, user_led2;
  logic i2s_tx_mclk0, i2s_tx0_clk, i2s_tx0_sync, i2s_tx0_tx;

  typedef struct {
    logic tx;
    logic sync;
    logic chk_led;
    logic led1;
    int   frame;
    int   slot;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk1000 = ~clk1000;

  audio_i2s_top #(.TONE_HALF(TH), .LED_DIV_BITS(6)) dut (
    .clk1000      (clk1000),
    .cpu_reset0   (cpu_reset0),
    .user_led0    (user_led0),
    .user_led1    (user_led1),
    .user_led2    (user_led2),
    .i2s_tx_mclk0 (i2s_tx_mclk0),
    .i2s_tx0_clk  (i2s_tx0_clk),
    .i2s_tx0_sync (i2s_tx0_sync),
    .i2s_tx0_tx   (i2s_tx0_tx)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return i2s_tx_mclk0;
      1:       return i2s_tx0_clk;
      2:       return i2s_tx0_sync;
      default: return user_led0;
    endcase
  endfunction

  // Hand-derived frame content: 0x2000 or 0xE000 MSB-first in slots 1..16 and
  // 33..48, zeros elsewhere; LED1 is checked at slot 0 of every frame.
  task automatic push_frame(input int f);
    logic [15:0] s;
    logic        neg;
    neg = ((f / TH) % 2) == 1;
    s   = neg ? 16'hE000 : 16'h2000;
    for (int si = 0; si < 64; si++) begin
      exp_t e;
      e.tx = 1'b0;
      if (si >= 1 && si <= 16)       e.tx = s[16-si];
      else if (si >= 33 && si <= 48) e.tx = s[48-si];
      e.sync    = (si >= 32);
      e.chk_led = (si == 0);
      e.led1    = ~neg;
      e.frame   = f;
      e.slot    = si;
      exp_q.push_back(e);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_led0"}, 32'(user_led0), 0);
    check({tag, "_led1"}, 32'(user_led1), 0);
    check({tag, "_led2"}, 32'(user_led2), 0);
    check({tag, "_mclk"}, 32'(i2s_tx_mclk0), 0);
    check({tag, "_bclk"}, 32'(i2s_tx0_clk), 0);
    check({tag, "_sync"}, 32'(i2s_tx0_sync), 0);
    check({tag, "_sd"},   32'(i2s_tx0_tx), 0);
  endtask

  // Counts clocks between three successive transitions: both half-periods.
  task automatic measure(input int sel, input int half, input string name);
    logic prev, cur;
    int   t[3];
    int   n = 0;
    int   c = 0;
    @(posedge clk1000); #1;
    prev = sig(sel);
    while (n < 3 && c < 5000) begin
      @(posedge clk1000); #1;
      c++;
      cur = sig(sel);
      if (cur != prev) begin
        t[n] = c;
        n++;
      end
      prev = cur;
    end
    if (n < 3) begin
      check({name, "_timeout"}, 32'(n), 3);
    end else begin
      check({name, "_half1_clks"}, 32'(t[1] - t[0]), 32'(half));
      check({name, "_half2_clks"}, 32'(t[2] - t[1]), 32'(half));
    end
  endtask

  task automatic wait_rise(input int sel, input int budget, input string name);
    logic prev, cur;
    int   c = 0;
    bit   seen = 0;
    @(posedge clk1000); #1;
    prev = sig(sel);
    while (!seen && c < budget) begin
      @(posedge clk1000); #1;
      c++;
      cur = sig(sel);
      seen = (cur && !prev);
      prev = cur;
    end
    if (!seen) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic drain(input int budget);
    int c = 0;
    while (exp_q.size() > 0 && c < budget) begin
      @(posedge clk1000);
      c++;
    end
    if (exp_q.size() > 0) begin
      check("drain_timeout", 32'(exp_q.size()), 0);
      exp_q.delete();
    end
  endtask

  // Monitor: each BCLK rising edge presents one slot bit and word select.
  initial begin
    forever begin
      @(posedge i2s_tx0_clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("sd_f%0d_s%0d", e.frame, e.slot), 32'(i2s_tx0_tx), 32'(e.tx));
        check($sformatf("ws_f%0d_s%0d", e.frame, e.slot), 32'(i2s_tx0_sync), 32'(e.sync));
        if (e.chk_led)
          check($sformatf("led1_f%0d", e.frame), 32'(user_led1), 32'(e.led1));
      end
    end
  end

  initial begin
    #100;
    check_all_zero("reset");
    #100;
    for (int f = 0; f < 10; f++) push_frame(f);
    #2;
    cpu_reset0 = 1'b1;
    #2;
    check("led2_before_first_clk", 32'(user_led2), 0);
    #3;
    check("led2_after_release", 32'(user_led2), 1);

    measure(0, 4, "mclk");
    measure(1, 16, "bclk");
    measure(2, 1024, "sync");
    measure(3, 32, "led0");
    drain(25000);

    // Mid-frame reset around slot 40 of the following frame.
    wait_rise(2, 3000, "sync_rise");
    for (int i = 0; i < 9; i++) wait_rise(1, 100, "bclk_rise");
    #3;
    cpu_reset0 = 1'b0;
    #1;
    check_all_zero("midreset");
    #99;
    push_frame(0);
    push_frame(1);
    cpu_reset0 = 1'b1;
    @(posedge clk1000); #1;
    check("led2_after_rerelease", 32'(user_led2), 1);
    drain(6000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_i2s_top.md
Name: audio_i2s_top

Overview:
- FPGA top level of the audio demo.
- Generates a fixed square-wave test tone and streams it out as a Philips I2S transmitter (MCLK, BCLK, WS, SD), all derived from one 100 MHz system clock.
- Drives three status LEDs.
- No host interface; runs autonomously after reset.

Parameters:
- AMPLITUDE, 16'h2000, positive tone level; negative level is its two's complement (16'hE000).
- TONE_HALF, 24, frames per tone half-period (about 1.017 kHz at 48.828 kHz).
- LED_DIV_BITS, 26, width of the heartbeat counter; its MSB drives user_led0.

Ports:
- clk1000 in 1: system clock, 100 MHz (10 ns period).
- cpu_reset0 in 1: reset, asynchronous, active-low.
- user_led0 out 1: heartbeat.
- user_led1 out 1: tone polarity (1 = positive half).
- user_led2 out 1: running indicator.
- i2s_tx_mclk0 out 1: I2S master clock, clk/8 = 12.5 MHz.
- i2s_tx0_clk out 1: I2S bit clock, clk/32 = 3.125 MHz.
- i2s_tx0_sync out 1: word select / LRCLK; 0 = left, 1 = right; clk/2048 = 48.828 kHz.
- i2s_tx0_tx out 1: serial data, MSB first.

Behaviour:
- Clock and reset: one clock, clk1000. Reset cpu_reset0 is asynchronous, active-low. While low, every register clears: div = 0, all outputs 0, tone polarity = positive, tone counter = 0, shift register = 0.
- Divider: 11-bit free-running counter div, +1 per clk, wraps 2047 -> 0.
  - mclk = div[2]; bclk = div[4]; slot n = div[10:5] (0..63).
  - All outputs are registered (one flop each), so each output lags its combinational source by exactly one clk, uniformly.
- BCLK edges:
  - Rising edge at div[4:0] = 16.
  - Falling edge at div[4:0] = 0; this is the slot boundary.
- Word select: sync = 0 for slots 0..31 and 1 for slots 32..63. It changes only on BCLK falling edges.
- Data framing (I2S one-bit delay):
  - Entering slot 1 (div 31 -> 32), a 64-bit shift register loads {S, 16'h0000, S, 16'h0000}, where S is the current 16-bit sample.
  - tx = shift register MSB.
  - The register shifts left, zero-fill, at every later slot boundary.
  - Left sample MSB therefore appears in slot 1 and right sample MSB in slot 33.
  - Slot 0 carries the final padding bit (0).
  - tx changes only coincident with BCLK falling edges and is stable across each rising edge.
- Sample source:
  - Both channels carry the same S.
  - S = AMPLITUDE if polarity positive, else -AMPLITUDE.
  - Tone counter increments at each shift-register load. On reaching TONE_HALF-1 it wraps to 0 and polarity toggles; the toggle takes effect from the next frame.
  - First frame after reset carries 16'h2000 and is positive for 24 frames, then 16'hE000 for 24 frames, repeating.
- LEDs:
  - user_led0 = MSB of a free-running LED_DIV_BITS counter.
  - user_led1 = polarity.
  - user_led2 = 0 in reset, 1 from the first clk after reset release, held.
- Reset mid-stream: outputs drop to 0 immediately (asynchronous). On release, framing restarts at div = 0, polarity positive; no partial-frame continuation.
- No handshakes, no back-pressure, no configuration registers.

Decomposition:
- Package audio_pkg:
  - Divider bit positions: MCLK bit 2, BCLK bit 4, slot field 10:5.
  - SLOT_BITS = 32, SAMPLE_W = 16, FRAME_SLOTS = 64.
  - Sample typedef: logic signed [15:0].
- Sub-module i2s_tx: divider, clock/WS generation and shift register. Takes sample input and produces a load strobe.
- The top holds the tone generator and LEDs.

Test Plan:
- Hold cpu_reset0 = 0 for 200 ns, then release -> all outputs 0 during reset; user_led2 = 1 one clk after release.
- Clock-ratio check -> measure periods: mclk = 80 ns, bclk = 320 ns, sync = 20.48 us; each 50 % duty.
- Sample frame 0 on BCLK rising edges -> left bits in slots 1..32 = 0x2000 followed by 16 zeros. Sync is 0 during slots 0..31 and 1 during 32..63. Right word in slots 33..63 plus next slot 0 is identical.
- Run 24 frames -> frame 24 carries 0xE000 on both channels and user_led1 falls to 0. Frame 48 returns to 0x2000 with user_led1 = 1.
- Assert reset mid-frame (e.g. in slot 40), release after 100 ns -> outputs 0 immediately. Next frame starts cleanly with sync = 0 and sample 0x2000.
- Reduce LED_DIV_BITS to 6 -> user_led0 toggles every 32 clks.
